// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: valid/ready handshake, flush, and a one-entry skid buffer.
// Optional EX_MEM_STALL_CNT_EN adds a saturating MEM-stall cycle counter (stall_cnt).
module ex_mem_pipe_reg #(
  parameter int SIZE      = 32,
  parameter int ADDR_SIZE = 5,
  parameter int S_WB      = 2,
  parameter int S_M       = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  input  logic [S_WB-1:0]      WB,
  input  logic [S_M-1:0]       M,
  input  logic [SIZE-1:0]      data_in,
  input  logic [SIZE-1:0]      data_in2,
  input  logic [ADDR_SIZE-1:0] AWriteMem_in,
  input  logic [ADDR_SIZE-1:0] AWriteReg_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [S_WB-1:0]      WB_out,
  output logic [S_M-1:0]       M_out,
  output logic [SIZE-1:0]      data_out,
  output logic [SIZE-1:0]      data_out2,
  output logic [ADDR_SIZE-1:0] AWriteMem,
  output logic [ADDR_SIZE-1:0] AWriteReg
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  typedef struct packed {
    logic [S_WB-1:0]      wb;
    logic [S_M-1:0]       m;
    logic [SIZE-1:0]      data;
    logic [SIZE-1:0]      data2;
    logic [ADDR_SIZE-1:0] amem;
    logic [ADDR_SIZE-1:0] areg;
  } entry_t;

  entry_t ent_p0;
  entry_t main_p1;
  entry_t skid_p1;
  logic   vld_p1;
  logic   skid_vld_p1;
  logic   accept;
  logic   consume;

  assign ent_p0 = '{wb: WB, m: M, data: data_in, data2: data_in2,
                    amem: AWriteMem_in, areg: AWriteReg_in};

  // in_ready comes straight from a flop, so it never sees out_ready combinationally.
  assign in_ready = ~skid_vld_p1;
  assign accept   = in_valid & in_ready;
  assign consume  = vld_p1 & out_ready;

  // ---- stage p0 -> p1: main/skid entry update ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      main_p1     <= '0;
      skid_p1     <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (skid_vld_p1 && consume) begin
      main_p1     <= skid_p1;
      vld_p1      <= 1'b1;
      skid_vld_p1 <= 1'b0;
    end else if (accept && (!vld_p1 || consume)) begin
      main_p1 <= ent_p0;
      vld_p1  <= 1'b1;
    end else if (accept) begin
      skid_p1     <= ent_p0;
      skid_vld_p1 <= 1'b1;
    end else if (consume) begin
      vld_p1 <= 1'b0;
    end
  end

  // Control fields of a bubble are zeroed so MEM/WB never act on stale bits.
  assign out_valid = vld_p1;
  assign WB_out    = main_p1.wb & {S_WB{vld_p1}};
  assign M_out     = main_p1.m & {S_M{vld_p1}};
  assign data_out  = main_p1.data;
  assign data_out2 = main_p1.data2;
  assign AWriteMem = main_p1.amem;
  assign AWriteReg = main_p1.areg;

`ifdef EX_MEM_STALL_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // ---- stall counter: not touched by flush ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (vld_p1 && !out_ready) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: vector table, hand-written corner sequences and a
// randomized run checked against a two-deep FIFO model.
module tb_ex_mem_pipe_reg;
  localparam int SIZE = 32, ADDR_SIZE = 5, S_WB = 2, S_M = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid, in_ready, flush, out_valid, out_ready;
  logic [S_WB-1:0]      WB, WB_out;
  logic [S_M-1:0]       M, M_out;
  logic [SIZE-1:0]      data_in, data_in2, data_out, data_out2;
  logic [ADDR_SIZE-1:0] AWriteMem_in, AWriteReg_in, AWriteMem, AWriteReg;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0]          stall_cnt;
`endif

  always #5 clk = ~clk;

  ex_mem_pipe_reg #(.SIZE(SIZE), .ADDR_SIZE(ADDR_SIZE), .S_WB(S_WB), .S_M(S_M)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .WB(WB), .M(M), .data_in(data_in), .data_in2(data_in2),
    .AWriteMem_in(AWriteMem_in), .AWriteReg_in(AWriteReg_in),
    .out_valid(out_valid), .out_ready(out_ready), .WB_out(WB_out), .M_out(M_out),
    .data_out(data_out), .data_out2(data_out2), .AWriteMem(AWriteMem), .AWriteReg(AWriteReg)
`ifdef EX_MEM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [S_WB-1:0]      wb;
    logic [S_M-1:0]       m;
    logic [SIZE-1:0]      d;
    logic [SIZE-1:0]      d2;
    logic [ADDR_SIZE-1:0] am;
    logic [ADDR_SIZE-1:0] ar;
  } pay_t;

  typedef struct packed {
    logic iv, ordy, fl;
    logic [1:0] wb;
    logic [2:0] m;
    logic [31:0] d;
    logic eov, eir;
    logic [31:0] ed;
    logic [1:0] ewb;
    logic [2:0] em;
    logic chkd;
  } vec_t;

  int chk_cnt = 0;
  int pass_cnt = 0;
  pay_t q[$];
  logic [31:0] mcnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic pay_t mk_pay(input logic [31:0] d, input logic [1:0] wb, input logic [2:0] m);
    pay_t p;
    p.wb = wb; p.m = m; p.d = d; p.d2 = ~d; p.am = d[4:0]; p.ar = d[9:5];
    return p;
  endfunction

  function automatic vec_t mkv(input logic iv, ordy, fl, input logic [1:0] wb, input logic [2:0] m,
                               input logic [31:0] d, input logic eov, eir, input logic [31:0] ed,
                               input logic [1:0] ewb, input logic [2:0] em, input logic chkd);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.wb = wb; v.m = m; v.d = d;
    v.eov = eov; v.eir = eir; v.ed = ed; v.ewb = ewb; v.em = em; v.chkd = chkd;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic ordy, input logic fl, input pay_t p);
    in_valid = iv; out_ready = ordy; flush = fl;
    WB = p.wb; M = p.m; data_in = p.d; data_in2 = p.d2;
    AWriteMem_in = p.am; AWriteReg_in = p.ar;
  endtask

  // Reference: the register pair behaves as a two-deep FIFO; ready while not full.
  task automatic tick();
    pay_t cur;
    logic cons, acc;
    cur  = mk_pay(data_in, WB, M);
    cur.d2 = data_in2; cur.am = AWriteMem_in; cur.ar = AWriteReg_in;
    cons = (q.size() > 0) && out_ready;
    acc  = in_valid && (q.size() < 2);
    if (q.size() > 0 && !out_ready && mcnt != 32'hFFFF_FFFF) mcnt++;
    if (flush) q.delete();
    else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      check({tag, "_wb"}, 64'(WB_out), 64'(q[0].wb));
      check({tag, "_m"}, 64'(M_out), 64'(q[0].m));
      check({tag, "_data"}, 64'(data_out), 64'(q[0].d));
      check({tag, "_data2"}, 64'(data_out2), 64'(q[0].d2));
      check({tag, "_addr"}, 64'({AWriteMem, AWriteReg}), 64'({q[0].am, q[0].ar}));
    end else begin
      check({tag, "_wb_bubble"}, 64'(WB_out), 64'd0);
      check({tag, "_m_bubble"}, 64'(M_out), 64'd0);
    end
`ifdef EX_MEM_STALL_CNT_EN
    check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(mcnt));
`endif
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    q.delete();
    mcnt = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vt[15];

  initial begin
    vt[0]  = mkv(1,1,0, 2'd1,3'd1, 32'h1,  1,1, 32'h1,  2'd1,3'd1, 1);
    vt[1]  = mkv(1,1,0, 2'd2,3'd2, 32'h2,  1,1, 32'h2,  2'd2,3'd2, 1);
    vt[2]  = mkv(1,1,0, 2'd3,3'd3, 32'h3,  1,1, 32'h3,  2'd3,3'd3, 1);
    vt[3]  = mkv(0,1,0, 2'd3,3'd7, 32'h0,  0,1, 32'h3,  2'd0,3'd0, 1);
    vt[4]  = mkv(1,1,0, 2'd1,3'd4, 32'h10, 1,1, 32'h10, 2'd1,3'd4, 1);
    vt[5]  = mkv(1,0,0, 2'd2,3'd5, 32'h20, 1,0, 32'h10, 2'd1,3'd4, 1);
    vt[6]  = mkv(0,0,0, 2'd0,3'd0, 32'h0,  1,0, 32'h10, 2'd1,3'd4, 1);
    vt[7]  = mkv(1,1,0, 2'd3,3'd6, 32'h99, 1,1, 32'h20, 2'd2,3'd5, 1);
    vt[8]  = mkv(0,1,0, 2'd0,3'd0, 32'h0,  0,1, 32'h20, 2'd0,3'd0, 1);
    vt[9]  = mkv(1,0,0, 2'd1,3'd1, 32'h30, 1,1, 32'h30, 2'd1,3'd1, 1);
    vt[10] = mkv(1,0,0, 2'd2,3'd2, 32'h40, 1,0, 32'h30, 2'd1,3'd1, 1);
    vt[11] = mkv(1,1,1, 2'd3,3'd3, 32'h50, 0,1, 32'h0,  2'd0,3'd0, 0);
    vt[12] = mkv(0,1,0, 2'd1,3'd1, 32'h0,  0,1, 32'h0,  2'd0,3'd0, 0);
    vt[13] = mkv(0,0,0, 2'd3,3'd7, 32'h0,  0,1, 32'h0,  2'd0,3'd0, 0);
    vt[14] = mkv(1,1,0, 2'd2,3'd6, 32'h60, 1,1, 32'h60, 2'd2,3'd6, 1);

    drive(1'b0, 1'b0, 1'b0, '0);
    mcnt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_data", 64'({data_out, data_out2}), 64'd0);
    check("rst_ctl", 64'({WB_out, M_out}), 64'd0);
    check("rst_addr", 64'({AWriteMem, AWriteReg}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].iv, vt[i].ordy, vt[i].fl, mk_pay(vt[i].d, vt[i].wb, vt[i].m));
      tick();
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vt[i].eov));
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vt[i].eir));
      check($sformatf("vec%0d_wb", i), 64'(WB_out), 64'(vt[i].ewb));
      check($sformatf("vec%0d_m", i), 64'(M_out), 64'(vt[i].em));
      if (vt[i].chkd) check($sformatf("vec%0d_data", i), 64'(data_out), 64'(vt[i].ed));
    end

    // Async reset while the skid entry is occupied.
    apply_reset();
    drive(1'b1, 1'b1, 1'b0, mk_pay(32'hA, 2'd3, 3'd7));
    tick();
    drive(1'b1, 1'b0, 1'b0, mk_pay(32'hB, 2'd2, 3'd5));
    tick();
    check("skid_full_in_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    check("async_rst_ctl", 64'({WB_out, M_out}), 64'd0);
    check("async_rst_data", 64'(data_out), 64'd0);
    q.delete();
    mcnt = '0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef EX_MEM_STALL_CNT_EN
    apply_reset();
    drive(1'b1, 1'b0, 1'b0, mk_pay(32'h77, 2'd1, 3'd1));
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    repeat (5) tick();
    check("stall_cnt_5", 64'(stall_cnt), 64'd5);
    drive(1'b0, 1'b1, 1'b1, '0);
    tick();
    check("stall_cnt_after_flush", 64'(stall_cnt), 64'd5);
    check("stall_flush_out_valid", 64'(out_valid), 64'd0);
`endif

    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      pay_t p;
      p.wb = 2'($urandom); p.m = 3'($urandom);
      p.d = $urandom; p.d2 = $urandom;
      p.am = 5'($urandom); p.ar = 5'($urandom);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 49) == 0, p);
      tick();
      check_model("rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
Parametrised EX/MEM pipeline register for the MIPS32 core, with a valid/ready handshake, flush and a one-entry skid buffer. The EX stage drives the input side and the MEM stage drives the output side. A MEM-side stall (such as a slow data memory) back-pressures EX one cycle later without losing an instruction. Control fields of invalid entries are forced to zero, so bubbles never write memory or registers.

Parameters:
SIZE, 32, width of ALU result and store-data buses
ADDR_SIZE, 5, width of register/memory address fields
S_WB, 2, width of writeback control bundle
S_M, 3, width of memory control bundle

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EX presents a valid instruction
in_ready  out  1  register can accept; registered, equals NOT skid_valid
flush  in  1  kill all held and incoming entries (branch/exception)
WB  in  S_WB  writeback control
M  in  S_M  memory control
data_in  in  SIZE  ALU result / address
data_in2  in  SIZE  store data
AWriteMem_in  in  ADDR_SIZE  memory address tag
AWriteReg_in  in  ADDR_SIZE  destination register
out_valid  out  1  main entry valid
out_ready  in  1  MEM consumes the entry this cycle
WB_out  out  S_WB  writeback control (0 when out_valid=0)
M_out  out  S_M  memory control (0 when out_valid=0)
data_out, data_out2  out  SIZE each  payload
AWriteMem, AWriteReg  out  ADDR_SIZE each  payload

Behaviour:
- Storage: main entry (drives outputs) and skid entry; each holds {valid, WB, M, data, data2, AWriteMem, AWriteReg}.
- Reset (rst_n=0, async): both valids=0, all payload and outputs=0, in_ready=1. Release is synchronous to the next clk edge.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Latency: accepted input appears on outputs at the next edge when the main entry is empty or consumed (1 cycle).
- Per edge, priority order:
  1. flush=1: main.valid=0, skid.valid=0; input in this cycle is discarded; payload registers are don't-care.
  2. Skid valid and consume: skid moves to main, skid.valid=0. in_ready is 0, so no accept can occur.
  3. Accept and (main empty or consume): input loads main.
  4. Accept and main full and no consume: input loads skid, skid.valid=1; in_ready falls next cycle.
  5. Consume with no replacement: main.valid=0.
- in_ready=0 only while skid is full. It must not depend combinationally on out_ready.
- Ordering is strictly FIFO; no entry is duplicated or dropped except by flush/reset.
- WB_out and M_out are ANDed with out_valid. Data/address outputs hold their last value while invalid.
- in_valid=0 with accept impossible: no state change except consume/flush.
- Reset asserted mid-stall clears both entries immediately, without waiting for clk.

Optional Feature:
EX_MEM_STALL_CNT_EN
- Defined: adds output stall_cnt [31:0].
  - Increments each cycle where out_valid=1 and out_ready=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by rst_n; not cleared by flush.
- Undefined: no port and no counter logic; the rest of the block is identical.

Test Plan:
- Reset then stream: in_valid=1, out_ready=1, data_in=1,2,3 on consecutive cycles -> data_out=1,2,3 one cycle later each; out_valid=1; in_ready stays 1.
- Backpressure: send A=0x10, B=0x20 with out_ready=0 from B's cycle -> B goes to skid, in_ready=0 next cycle, outputs hold A. Raise out_ready -> outputs A then B, in_ready returns 1, no loss.
- Flush with both entries full plus in_valid=1 -> next cycle out_valid=0, WB_out=0, M_out=0, in_ready=1; discarded input never appears.
- Bubble: in_valid=0 with WB=2'b11, M=3'b111 -> WB_out=0, M_out=0 while out_valid=0.
- Async reset mid-stall: skid full, drop rst_n between edges -> outputs and valids go to 0 and in_ready to 1 before the next clk edge.
- With EX_MEM_STALL_CNT_EN: hold out_ready=0 for 5 cycles with a valid entry -> stall_cnt=5. Flush -> stall_cnt still 5.
